// File: rtl/clb_cfg_pkg.sv
// Shared CLB configuration definitions: readback FSM encoding, select-width helper, slice defaults.
// Latency: none; this file holds only constants, types and a constant function.
// Backpressure: not applicable.
package clb_cfg_pkg;

  localparam int DEF_ADDR_BITS = 4;
  localparam int DEF_NUM_LUTS  = 4;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_SETUP  = 3'd1;
  localparam logic [2:0] ENC_SAMPLE = 3'd2;
  localparam logic [2:0] ENC_SEND   = 3'd3;
  localparam logic [2:0] ENC_FINISH = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_SETUP  = ENC_SETUP,
    ST_SAMPLE = ENC_SAMPLE,
    ST_SEND   = ENC_SEND,
    ST_FINISH = ENC_FINISH
  } rb_state_t;

  // A single-LUT chain still needs a one-bit select so the port never collapses to zero width.
  function automatic int sel_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/readback_addr_counter.sv
// Nested LUT address / LUT select counter: address is the inner loop, select the outer loop.
// Latency: clear and advance take effect on the next cclk edge; last_bit is combinational.
// Backpressure: advances only when the owner pulses adv; saturates at the final bit, never wraps.
module readback_addr_counter #(
  parameter int ADDR_BITS = 4,
  parameter int MEM_SIZE  = 2**ADDR_BITS,
  parameter int NUM_LUTS  = 4,
  parameter int SEL_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 adv,
  output logic [ADDR_BITS-1:0] addr,
  output logic [SEL_BITS-1:0]  sel,
  output logic                 last_bit
);

  logic addr_max;
  logic sel_max;

  assign addr_max = (addr == ADDR_BITS'(MEM_SIZE - 1));
  assign sel_max  = (sel  == SEL_BITS'(NUM_LUTS - 1));
  assign last_bit = addr_max && sel_max;

  // Step the address first, roll into the next LUT at the end of a LUT, hold at the very end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      sel  <= '0;
    end else if (clr) begin
      addr <= '0;
      sel  <= '0;
    end else if (adv) begin
      if (!addr_max) begin
        addr <= addr + 1'b1;
      end else if (!sel_max) begin
        addr <= '0;
        sel  <= sel + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lut_config_readback.sv
// Serial readback of every LUT bit (LUT 0 first, address 0 first) over a valid/ready stream.
// Latency: 3 cycles per bit at full rate; first valid 2 cycles after start; done 3*N+1 after start.
// Backpressure: dout/dout_valid/dout_last hold until dout_ready; cfg_busy aborts to idle.
module lut_config_readback
  import clb_cfg_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int MEM_SIZE  = 2**ADDR_BITS,
  parameter int NUM_LUTS  = DEF_NUM_LUTS,
  parameter int SEL_BITS  = sel_bits(NUM_LUTS)
) (
  input  logic                 cclk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cfg_busy,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic [SEL_BITS-1:0]  rd_sel,
  input  logic [NUM_LUTS-1:0]  lut_out,
  output logic                 dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_last,
  output logic                 busy,
  output logic                 done,
  output logic                 abort
);

  localparam int PAD = 1 << SEL_BITS;

  rb_state_t        state, state_nx;
  logic             rd_en_nx, busy_nx, dout_nx, valid_nx, last_nx, done_nx, abort_nx;
  logic             cnt_clr, cnt_adv, cnt_last;
  logic [PAD-1:0]   lut_pad;

  readback_addr_counter #(
    .ADDR_BITS (ADDR_BITS),
    .MEM_SIZE  (MEM_SIZE),
    .NUM_LUTS  (NUM_LUTS),
    .SEL_BITS  (SEL_BITS)
  ) u_cnt (
    .clk      (cclk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .adv      (cnt_adv),
    .addr     (rd_addr),
    .sel      (rd_sel),
    .last_bit (cnt_last)
  );

  // Widen the LUT outputs to the full select range so rd_sel always indexes in bounds.
  always_comb begin
    lut_pad                 = '0;
    lut_pad[NUM_LUTS-1:0]   = lut_out;
  end

  // Next-state and next-output decode; a config load in progress overrides everything.
  always_comb begin
    state_nx = state;
    rd_en_nx = rd_en;
    busy_nx  = busy;
    dout_nx  = dout;
    valid_nx = dout_valid;
    last_nx  = dout_last;
    done_nx  = 1'b0;
    abort_nx = 1'b0;
    cnt_clr  = 1'b0;
    cnt_adv  = 1'b0;
    if (state != ST_IDLE && cfg_busy) begin
      state_nx = ST_IDLE;
      rd_en_nx = 1'b0;
      busy_nx  = 1'b0;
      valid_nx = 1'b0;
      last_nx  = 1'b0;
      abort_nx = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !cfg_busy) begin
            cnt_clr  = 1'b1;
            rd_en_nx = 1'b1;
            busy_nx  = 1'b1;
            state_nx = ST_SETUP;
          end
        end
        ST_SETUP: begin
          state_nx = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          dout_nx  = lut_pad[rd_sel];
          valid_nx = 1'b1;
          last_nx  = cnt_last;
          state_nx = ST_SEND;
        end
        ST_SEND: begin
          if (dout_ready) begin
            valid_nx = 1'b0;
            last_nx  = 1'b0;
            if (cnt_last) begin
              state_nx = ST_FINISH;
            end else begin
              cnt_adv  = 1'b1;
              state_nx = ST_SETUP;
            end
          end
        end
        ST_FINISH: begin
          rd_en_nx = 1'b0;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
        end
        default: begin
          state_nx = ST_IDLE;
          rd_en_nx = 1'b0;
          busy_nx  = 1'b0;
          valid_nx = 1'b0;
          last_nx  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset truncates any stream without a done or abort pulse.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rd_en      <= 1'b0;
      busy       <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      done       <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state      <= state_nx;
      rd_en      <= rd_en_nx;
      busy       <= busy_nx;
      dout       <= dout_nx;
      dout_valid <= valid_nx;
      dout_last  <= last_nx;
      done       <= done_nx;
      abort      <= abort_nx;
    end
  end

endmodule

// File: tb/tb_lut_config_readback.sv
// Bench for lut_config_readback: directed scenarios plus randomized LUT contents and ready.
// Latency: expected stream is mem[k/16][k%16] for bit k; timing figures come from the cycle budget.
// Backpressure: drives dout_ready (fixed, stalled or random) and checks holding behaviour.
module tb_lut_config_readback;

  localparam int AB = 4;
  localparam int NL = 4;
  localparam int MS = 16;
  localparam int SB = 2;
  localparam int NB = NL * MS;

  logic cclk = 1'b0;
  always #5 cclk = ~cclk;

  logic          rst_n, start, cfg_busy, dout_ready;
  logic          rd_en, dout, dout_valid, dout_last, busy, done, abort;
  logic [AB-1:0] rd_addr;
  logic [SB-1:0] rd_sel;
  logic [NL-1:0] lut_out;
  logic [MS-1:0] mem [NL];

  logic       s_start, s_cfg_busy, s_ready;
  logic       s_rd_en, s_dout, s_valid, s_last, s_busy, s_done, s_abort;
  logic [1:0] s_rd_addr;
  logic [0:0] s_rd_sel;
  logic [0:0] s_lut_out;
  logic [3:0] s_mem;

  // Behavioural LUTs: each LUT outputs the stored bit at the fabric-routed address.
  always_comb begin
    for (int i = 0; i < NL; i++) lut_out[i] = mem[i][rd_addr];
  end
  assign s_lut_out[0] = s_mem[s_rd_addr];

  lut_config_readback dut (
    .cclk(cclk), .rst_n(rst_n), .start(start), .cfg_busy(cfg_busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_sel(rd_sel), .lut_out(lut_out),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .busy(busy), .done(done), .abort(abort)
  );

  lut_config_readback #(.ADDR_BITS(2), .NUM_LUTS(1)) dut_s (
    .cclk(cclk), .rst_n(rst_n), .start(s_start), .cfg_busy(s_cfg_busy),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_sel(s_rd_sel), .lut_out(s_lut_out),
    .dout(s_dout), .dout_valid(s_valid), .dout_ready(s_ready), .dout_last(s_last),
    .busy(s_busy), .done(s_done), .abort(s_abort)
  );

  int checks = 0;
  int errors = 0;

  int got[$];
  int last_pos, nlast, done_cyc, abort_cyc, first_vld, busy_cyc;
  bit rst_hit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input int k);
    return mem[k / MS][k % MS];
  endfunction

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int n);
    check({tag, "_len"}, 32'(got.size()), 32'(n));
    for (int k = 0; k < got.size() && k < n; k++)
      check($sformatf("%s_bit%0d", tag, k), 32'(got[k]), 32'(exp_bit(k)));
  endtask

  // Consumer: c counts cclk edges since the start edge; a handshake is valid&&ready at the next edge.
  task automatic collect(input int stall_at, input int abort_at, input int rst_at,
                         input int start_cyc, input bit rnd, input int max_cyc);
    int stall_left;
    bit stalled;
    stall_left = 0;
    stalled    = 1'b0;
    got.delete();
    last_pos = -1; nlast = 0; done_cyc = -1; abort_cyc = -1; first_vld = -1; busy_cyc = -1;
    rst_hit  = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      start = (start_cyc > 0 && c == start_cyc);
      if (done) begin done_cyc = c; break; end
      if (abort) begin abort_cyc = c; break; end
      if (dout_valid && first_vld < 0) first_vld = c;
      dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_at >= 0 && !stalled && dout_valid && got.size() == stall_at) begin
        stalled    = 1'b1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        dout_ready = 1'b0;
        stall_left--;
        check("stall_dout", 32'(dout), 32'(exp_bit(stall_at)));
        check("stall_vld", 32'(dout_valid), 32'd1);
        check("stall_last", 32'(dout_last), 32'(stall_at == NB - 1));
      end
      if (dout_valid) begin
        if (rst_at >= 0 && got.size() == rst_at) begin
          #2 rst_n = 1'b0;
          #1;
          check("rst_vld", 32'(dout_valid), 32'd0);
          check("rst_busy", 32'(busy), 32'd0);
          check("rst_rden", 32'(rd_en), 32'd0);
          check("rst_dout", 32'(dout), 32'd0);
          check("rst_last", 32'(dout_last), 32'd0);
          check("rst_addr", 32'(rd_addr), 32'd0);
          check("rst_sel", 32'(rd_sel), 32'd0);
          check("rst_done", 32'(done), 32'd0);
          rst_hit = 1'b1;
          break;
        end
        if (abort_at >= 0 && got.size() == abort_at && busy_cyc < 0) begin
          cfg_busy   = 1'b1;
          dout_ready = 1'b1;
          busy_cyc   = c;
        end
        if (dout_ready && !cfg_busy) begin
          got.push_back(int'(dout));
          if (dout_last) begin
            last_pos = got.size() - 1;
            nlast++;
          end
        end
      end
      step();
      cfg_busy = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    int s_got[$];
    int s_lastpos, s_donecyc, sel_bad;
    logic seen;

    rst_n = 1'b0; start = 1'b0; cfg_busy = 1'b0; dout_ready = 1'b0;
    s_start = 1'b0; s_cfg_busy = 1'b0; s_ready = 1'b1;
    mem[0] = 16'hA5C3; mem[1] = 16'h0001; mem[2] = 16'h8000; mem[3] = 16'hFFFF;
    s_mem = 4'b0110;

    // Reset state
    repeat (3) step();
    check("reset_rden", 32'(rd_en), 32'd0);
    check("reset_addr", 32'(rd_addr), 32'd0);
    check("reset_sel", 32'(rd_sel), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_vld", 32'(dout_valid), 32'd0);
    check("reset_last", 32'(dout_last), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_abort", 32'(abort), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed pattern at full rate
    do_start();
    collect(-1, -1, -1, -1, 1'b0, 400);
    check_stream("full", NB);
    check("full_lastpos", 32'(last_pos), 32'd63);
    check("full_nlast", 32'(nlast), 32'd1);
    check("full_first_vld", 32'(first_vld), 32'd2);
    check("full_done_cyc", 32'(done_cyc), 32'd193);
    check("full_busy_at_done", 32'(busy), 32'd0);
    check("full_rden_at_done", 32'(rd_en), 32'd0);
    step();
    check("full_done_pulse", 32'(done), 32'd0);
    repeat (2) step();

    // Backpressure at bit 17
    do_start();
    collect(17, -1, -1, -1, 1'b0, 400);
    check_stream("bp", NB);
    if (got.size() > 17) check("bp_bit17", 32'(got[17]), 32'd0);
    else check("bp_bit17_present", 32'(got.size()), 32'd18);
    check("bp_done_cyc", 32'(done_cyc), 32'd198);
    repeat (2) step();

    // Abort from cfg_busy during SEND of bit 30
    do_start();
    collect(-1, 30, -1, -1, 1'b0, 400);
    check_stream("abort_prefix", 30);
    check("abort_cyc", 32'(abort_cyc), 32'(busy_cyc + 1));
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rden", 32'(rd_en), 32'd0);
    check("abort_vld", 32'(dout_valid), 32'd0);
    check("abort_nodone", 32'(done), 32'd0);
    step();
    check("abort_pulse", 32'(abort), 32'd0);
    repeat (2) step();

    // Restart after abort with random contents, random ready, and a start while busy
    for (int i = 0; i < NL; i++) mem[i] = 16'($urandom);
    do_start();
    collect(-1, -1, -1, 20, 1'b1, 3000);
    check_stream("rnd", NB);
    check("rnd_lastpos", 32'(last_pos), 32'd63);
    check("rnd_nlast", 32'(nlast), 32'd1);
    check("rnd_done_seen", 32'(done_cyc >= 0), 32'd1);
    repeat (2) step();

    // start together with cfg_busy in IDLE is dropped
    start = 1'b1; cfg_busy = 1'b1;
    step();
    start = 1'b0; cfg_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ign_busy%0d", i), 32'(busy), 32'd0);
      check($sformatf("ign_vld%0d", i), 32'(dout_valid), 32'd0);
      step();
    end
    check("ign_rden", 32'(rd_en), 32'd0);

    // Asynchronous reset mid bit 40
    do_start();
    collect(-1, -1, 40, -1, 1'b0, 400);
    check("rst_hit", 32'(rst_hit), 32'd1);
    repeat (2) @(posedge cclk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | done | abort | busy;
      step();
    end
    check("rst_no_pulse", 32'(seen), 32'd0);

    // Complete stream after reset
    do_start();
    collect(-1, -1, -1, -1, 1'b0, 400);
    check_stream("post_rst", NB);
    check("post_rst_done_cyc", 32'(done_cyc), 32'd193);
    repeat (2) step();

    // Single-LUT, 2-bit-address instance
    s_lastpos = -1; s_donecyc = -1; sel_bad = 0;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (s_done) begin s_donecyc = c; break; end
      if (s_busy && s_rd_sel != 1'b0) sel_bad++;
      if (s_valid) begin
        s_got.push_back(int'(s_dout));
        if (s_last) s_lastpos = s_got.size() - 1;
      end
      step();
    end
    check("small_len", 32'(s_got.size()), 32'd4);
    for (int k = 0; k < s_got.size() && k < 4; k++)
      check($sformatf("small_bit%0d", k), 32'(s_got[k]), 32'(s_mem[k]));
    check("small_lastpos", 32'(s_lastpos), 32'd3);
    check("small_done_cyc", 32'(s_donecyc), 32'd13);
    check("small_sel_zero", 32'(sel_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_config_readback.md
Name: lut_config_readback

Overview:
- Readback engine for the CLB's bit-writable LUT memories: the read side of the LUT configuration path.
- On a start request it walks every LUT in the slice (LUT 0 first) and every address (0 to MEM_SIZE-1) of each LUT.
- It samples each LUT's combinational output and streams the bits out serially over a valid/ready handshake.
- Bit order matches the config_in word used at load time (bit 0 = mem[0]), so a readback stream can be compared directly against the loaded bitstream.

Parameters:
- ADDR_BITS, 4, LUT address width.
- MEM_SIZE, 2**ADDR_BITS, bits per LUT.
- NUM_LUTS, 4, LUTs in the readback chain.
- SEL_BITS, max(1, clog2(NUM_LUTS)), LUT select width.

Ports:
- cclk  in  1  configuration clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle readback request.
- cfg_busy  in  1  configuration load (cen) in progress elsewhere in the slice.
- rd_en  out  1  fabric routes rd_addr onto the LUT addr inputs while high.
- rd_addr  out  ADDR_BITS  address driven to the LUTs.
- rd_sel  out  SEL_BITS  index of the LUT being read.
- lut_out  in  NUM_LUTS  the LUT outputs; bit i = out of LUT i.
- dout  out  1  readback data bit.
- dout_valid  out  1  dout is valid.
- dout_ready  in  1  consumer accepts dout.
- dout_last  out  1  qualifies the final bit (LUT NUM_LUTS-1, addr MEM_SIZE-1).
- busy  out  1  readback in progress.
- done  out  1  one-cycle pulse on normal completion.
- abort  out  1  one-cycle pulse when cfg_busy interrupts a readback.

Behaviour:
- Reset values (async on rst_n low): all outputs 0; state IDLE; address and select counters 0.
- FSM states: IDLE, SETUP, SAMPLE, SEND, FINISH.
- IDLE:
  - start=1 and cfg_busy=0: load rd_addr=0, rd_sel=0, set rd_en=1 and busy=1, go to SETUP.
  - start with cfg_busy=1: ignored; no pending request is kept.
  - start while busy: ignored.
- SETUP: one settle cycle with rd_addr and rd_sel stable; go to SAMPLE.
- SAMPLE:
  - Register dout <= lut_out[rd_sel].
  - Set dout_valid=1.
  - Set dout_last=1 if rd_sel==NUM_LUTS-1 and rd_addr==MEM_SIZE-1.
  - Go to SEND.
- SEND:
  - Hold dout, dout_valid and dout_last stable until dout_ready=1.
  - On the handshake, clear dout_valid and dout_last, then:
    - rd_addr < MEM_SIZE-1: rd_addr+1, go to SETUP.
    - rd_addr == MEM_SIZE-1 and rd_sel < NUM_LUTS-1: rd_addr=0, rd_sel+1, go to SETUP.
    - final bit: go to FINISH.
- FINISH: deassert rd_en and busy, pulse done for 1 cycle, go to IDLE.
- Latency:
  - 3 cycles per bit with dout_ready tied high.
  - First dout_valid rises 2 cycles after the start edge.
  - Full readback takes 3*NUM_LUTS*MEM_SIZE + 1 cycles from start to done.
- cfg_busy=1 in any non-IDLE state:
  - Next edge: clear dout_valid, dout_last, rd_en and busy; pulse abort; go to IDLE.
  - No partial-bit handshake completes.
  - A SEND handshake that coincides with cfg_busy is discarded, because abort wins.
- rd_addr and rd_sel do not wrap beyond their limits. Counters are only advanced in SEND.
- dout_valid never drops without a handshake, except on abort or reset.
- Reset mid-readback: immediate return to reset values; the stream is truncated; no done or abort pulse.
- The module never drives cen or any write enable; readback is non-destructive.

Decomposition:
- Shared package (clb_cfg_pkg):
  - FSM state encoding (localparams for IDLE, SETUP, SAMPLE, SEND, FINISH).
  - SEL_BITS derivation function.
  - Default ADDR_BITS and NUM_LUTS, shared with the LUT and config loader.
- One natural sub-module: readback_addr_counter.
  - Nested rd_addr/rd_sel counter with clear, advance and last_bit flag.
  - Reusable by the future config loader.
- The FSM and output registers stay in the top module.

Test Plan:
- Load LUT0=16'hA5C3, LUT1=16'h0001, LUT2=16'h8000, LUT3=16'hFFFF; start with dout_ready=1 -> 64 bits LSB-first per LUT, LUT0 first; dout_last only on bit 63; done 193 cycles after start.
- Backpressure: dout_ready low for 5 cycles at bit 17 -> dout, dout_valid and dout_last stable throughout; bit 17 equals LUT1[1]=0; no bits lost or duplicated.
- cfg_busy asserted during SEND of bit 30 -> abort pulse next cycle; busy, rd_en and dout_valid go to 0; a later start re-reads from bit 0.
- start while busy, and start with cfg_busy=1 in IDLE -> both ignored; the stream is unchanged and busy stays 0 in the second case.
- rst_n pulsed low asynchronously mid-bit 40 -> all outputs 0 immediately; no done pulse; the next start yields a complete 64-bit stream.
- NUM_LUTS=1, ADDR_BITS=2 configuration with LUT=4'b0110 -> stream 0,1,1,0; dout_last on the 4th bit; SEL_BITS=1 with rd_sel held at 0.
